// File: rtl/deserialize_circuit_pkg.sv
// +----------------------------------------------------------------------------+
// | deserialize_circuit_pkg : shared width helpers for the serializer pair     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package deserialize_circuit_pkg;

  function automatic int slice_width(input int data_width, input int divide_num);
    return data_width / divide_num;
  endfunction

  // Counter must be at least one bit wide even when a word is a single slice.
  function automatic int cnt_width(input int divide_num);
    return (divide_num <= 1) ? 1 : $clog2(divide_num);
  endfunction

  function automatic bit widths_ok(input int data_width, input int divide_num);
    return (divide_num >= 1) && ((data_width % divide_num) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/deserialize_circuit.sv
// +----------------------------------------------------------------------------+
// | deserialize_circuit : gathers DIVIDE_NUM slices into one DATA_WIDTH word   |
// | Optional: DESERIALIZE_MSB_FIRST_EN places the first slice at the top.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module deserialize_circuit
  import deserialize_circuit_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DIVIDE_NUM = 4
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst_n,
  input  logic                                               i_valid,
  input  logic                                               i_sof,
  input  logic [slice_width(DATA_WIDTH, DIVIDE_NUM)-1:0]     i_data,
  output logic [DATA_WIDTH-1:0]                              o_data,
  output logic                                               o_valid,
  output logic                                               o_err
);

  localparam int SLICE_W = slice_width(DATA_WIDTH, DIVIDE_NUM);
  localparam int CNT_W   = cnt_width(DIVIDE_NUM);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIVIDE_NUM - 1);

  if (!widths_ok(DATA_WIDTH, DIVIDE_NUM)) begin : g_bad_params
    $error("deserialize_circuit: DIVIDE_NUM must be >= 1 and divide DATA_WIDTH");
  end

  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] coll_q,  coll_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  err_q,   err_d;
  logic [CNT_W-1:0]      idx;

  function automatic int slot_base(input int k);
`ifdef DESERIALIZE_MSB_FIRST_EN
    return (DIVIDE_NUM - 1 - k) * SLICE_W;
`else
    return k * SLICE_W;
`endif
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    idx     = i_sof ? '0 : cnt_q;
    if (i_valid) begin
      for (int k = 0; k < DIVIDE_NUM; k++) begin
        if (idx == CNT_W'(k)) begin
          coll_d[slot_base(k) +: SLICE_W] = i_data;
        end
      end
      err_d = i_sof && (cnt_q != '0);
      // Completed word is taken from coll_d so the final slice bypasses the register.
      if (idx == LAST_IDX) begin
        data_d  = coll_d;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      coll_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_deserialize_circuit.sv
// +----------------------------------------------------------------------------+
// | tb_deserialize_circuit : scoreboard bench for deserialize_circuit          |
// | Honours DESERIALIZE_MSB_FIRST_EN when building expected words.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_deserialize_circuit;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         i_sof;
  logic [31:0]  i_data;
  logic [127:0] o_data;
  logic         o_valid;
  logic         o_err;

  int tests  = 0;
  int failed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_word;

  deserialize_circuit #(.DATA_WIDTH(128), .DIVIDE_NUM(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [127:0] pack(input logic [31:0] s0, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] s3);
`ifdef DESERIALIZE_MSB_FIRST_EN
    return {s0, s1, s2, s3};
`else
    return {s3, s2, s1, s0};
`endif
  endfunction

  // Applies inputs for one edge, then leaves outputs settled for inspection.
  task automatic drive(input logic v, input logic sof, input logic [31:0] d);
    i_valid = v;
    i_sof   = sof;
    i_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    tests++; if (o_data !== 128'h0) begin failed++; $display("FAIL reset_data got=%h exp=0", o_data); end
    tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    tests++; if (o_err !== 1'b0) begin failed++; $display("FAIL reset_err got=%b exp=0", o_err); end
    i_rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_basic();
    logic [127:0] e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(pack(32'h1, 32'h2, 32'h3, 32'h4));
      drive(1'b1, i == 0, 32'(i + 1));
      tests++; if (o_valid !== (i == 3)) begin failed++; $display("FAIL basic_valid slice=%0d got=%b exp=%b", i, o_valid, i == 3); end
      tests++; if (o_err !== 1'b0) begin failed++; $display("FAIL basic_err slice=%0d got=%b exp=0", i, o_err); end
      if (o_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front(); last_word = e;
        tests++; if (o_data !== e) begin failed++; $display("FAIL basic_data got=%h exp=%h", o_data, e); end
      end
    end
    drive(1'b0, 1'b1, 32'hDEAD);
    tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL basic_pulse_width got=%b exp=0", o_valid); end
    tests++; if (o_data !== last_word) begin failed++; $display("FAIL basic_hold got=%h exp=%h", o_data, last_word); end
  endtask

  task automatic test_gapped();
    logic [127:0] e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(pack(32'h1, 32'h2, 32'h3, 32'h4));
      drive(1'b1, i == 0, 32'(i + 1));
      tests++; if (o_valid !== (i == 3)) begin failed++; $display("FAIL gap_valid slice=%0d got=%b exp=%b", i, o_valid, i == 3); end
      if (o_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front(); last_word = e;
        tests++; if (o_data !== e) begin failed++; $display("FAIL gap_data got=%h exp=%h", o_data, e); end
      end
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          drive(1'b0, 1'b0, 32'hFFFF_FFFF);
          tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL gap_idle_valid slice=%0d got=%b exp=0", i, o_valid); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) exp_q.push_back(pack(32'h1, 32'h2, 32'h3, 32'h4));
      if (i == 7) exp_q.push_back(pack(32'h5, 32'h6, 32'h7, 32'h8));
      drive(1'b1, i == 0, 32'(i + 1));
      tests++; if (o_valid !== (i == 3 || i == 7)) begin failed++; $display("FAIL b2b_valid slice=%0d got=%b", i, o_valid); end
      if (o_valid) pulses++;
      if (o_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front(); last_word = e;
        tests++; if (o_data !== e) begin failed++; $display("FAIL b2b_data slice=%0d got=%h exp=%h", i, o_data, e); end
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    tests++; if (pulses != 2) begin failed++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_resync();
    logic [127:0] e;
    logic [31:0]  d [6] = '{32'hA, 32'hB, 32'h1, 32'h2, 32'h3, 32'h4};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) exp_q.push_back(pack(32'h1, 32'h2, 32'h3, 32'h4));
      drive(1'b1, i == 0 || i == 2, d[i]);
      tests++; if (o_err !== (i == 2)) begin failed++; $display("FAIL resync_err step=%0d got=%b exp=%b", i, o_err, i == 2); end
      tests++; if (o_valid !== (i == 5)) begin failed++; $display("FAIL resync_valid step=%0d got=%b exp=%b", i, o_valid, i == 5); end
      if (i == 2) begin
        tests++; if (o_data !== last_word) begin failed++; $display("FAIL resync_hold got=%h exp=%h", o_data, last_word); end
      end
      if (o_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front(); last_word = e;
        tests++; if (o_data !== e) begin failed++; $display("FAIL resync_data got=%h exp=%h", o_data, e); end
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    tests++; if (o_err !== 1'b0) begin failed++; $display("FAIL resync_err_idle got=%b exp=0", o_err); end
  endtask

  task automatic test_reset_mid_word();
    logic [127:0] e;
    int pulses = 0;
    drive(1'b1, 1'b1, 32'h9);
    drive(1'b1, 1'b0, 32'h10);
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    i_rst_n = 1'b1;
    tests++; if (o_data !== 128'h0) begin failed++; $display("FAIL midrst_data got=%h exp=0", o_data); end
    tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    // No sof here: the count itself must have been cleared by reset.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(pack(32'h11, 32'h12, 32'h13, 32'h14));
      drive(1'b1, 1'b0, 32'(32'h11 + i));
      if (o_valid) pulses++;
      tests++; if (o_valid !== (i == 3)) begin failed++; $display("FAIL midrst_post_valid slice=%0d got=%b exp=%b", i, o_valid, i == 3); end
      if (o_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++; if (o_data !== e) begin failed++; $display("FAIL midrst_post_data got=%h exp=%h", o_data, e); end
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    tests++; if (pulses != 1) begin failed++; $display("FAIL midrst_pulses got=%0d exp=1", pulses); end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_data  = '0;
    last_word = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_resync();
    test_reset_mid_word();
    tests++; if (exp_q.size() != 0) begin failed++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
